fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction cache: owns the PC and drives cache addr/rd.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues cache reads, and queues hit
// instructions with their PCs into a small FIFO toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [31:0] o_cache_addr,
    output logic        o_cache_rd,
    input  logic [31:0] i_cache_inst,
    input  logic        i_cache_hit,
    input  logic        i_cache_busy,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {RUN, MISS, REDIR} state_t;

    state_t             state, state_nxt;
    logic [31:0]        pc, pc_nxt;
    logic [31:0]        pend, pend_nxt;
    logic [31:0]        target;
    logic [31:0]        mem_inst [FIFO_DEPTH];
    logic [31:0]        mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_full, push, pop;

    assign target       = {i_redirect_pc[31:2], 2'b00};
    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign o_cache_addr = pc;
    assign o_cache_rd   = !i_reset && !fifo_full && (state != REDIR || i_cache_busy);
    assign push         = i_cache_hit && o_cache_rd && (state == RUN) && !i_redirect;
    assign o_valid      = !i_reset && (count != '0);
    assign pop          = o_valid && i_ready;
    assign o_inst       = mem_inst[rd_ptr];
    assign o_pc         = mem_pc[rd_ptr];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend;
        if (push) pc_nxt = pc + 32'd4;
        case (state)
            RUN: begin
                if (i_redirect) begin
                    if (i_cache_busy) begin
                        pend_nxt  = target;
                        state_nxt = REDIR;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (i_cache_busy) begin
                    state_nxt = MISS;
                end
            end
            MISS: begin
                if (i_redirect) begin
                    pend_nxt  = target;
                    state_nxt = REDIR;
                end else if (!i_cache_busy) begin
                    state_nxt = RUN;
                end
            end
            REDIR: begin
                // A redirect landing on the refill-end cycle is the newest target.
                if (!i_cache_busy) begin
                    pc_nxt    = i_redirect ? target : pend;
                    state_nxt = RUN;
                end else if (i_redirect) begin
                    pend_nxt = target;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= RUN;
            pc     <= RESET_PC;
            pend   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pend  <= pend_nxt;
            if (i_redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_inst[wr_ptr] <= i_cache_inst;
            mem_pc[wr_ptr]   <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scripted cache model plus a stream
// model requiring delivered PCs to be sequential from the latest reset/redirect.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_ready = 1'b1;
    logic        i_cache_busy = 1'b0;
    logic        i_cache_hit;
    logic [31:0] i_cache_inst;
    logic [31:0] o_cache_addr, o_inst, o_pc;
    logic        o_cache_rd, o_valid;

    logic [31:0] miss_addr   = 32'hFFFF_FFFF;
    logic [31:0] last_missed = 32'hFFFF_FFFF;
    int unsigned miss_len = 0;
    int unsigned busy_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .o_cache_addr(o_cache_addr), .o_cache_rd(o_cache_rd),
        .i_cache_inst(i_cache_inst), .i_cache_hit(i_cache_hit), .i_cache_busy(i_cache_busy),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a * 32'd3 + 32'h1234_5677;
    endfunction

    // Cache: hits any read unless refilling or the armed miss address is requested.
    assign i_cache_hit  = o_cache_rd && !i_cache_busy &&
                          !(o_cache_addr == miss_addr && miss_addr != last_missed);
    assign i_cache_inst = inst_of(o_cache_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clock);
    endtask

    task automatic do_reset();
        i_reset    = 1'b1;
        i_redirect = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            mid();
            if (i_cache_busy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Cache refill sequencer
    initial begin
        logic st, rs;
        forever begin
            @(negedge i_clock);
            st = o_cache_rd && o_cache_addr == miss_addr && miss_addr != last_missed && !i_cache_busy;
            rs = i_reset;
            @(posedge i_clock);
            #1;
            if (rs) begin
                i_cache_busy = 1'b0;
                busy_cnt     = 0;
            end else if (st) begin
                i_cache_busy = 1'b1;
                busy_cnt     = miss_len;
                last_missed  = miss_addr;
            end else if (i_cache_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) i_cache_busy = 1'b0;
            end
        end
    end

    // Stream model: each transfer must be the next sequential PC since the last reset/redirect.
    initial begin
        logic [31:0] exp_next, prev_addr;
        logic        prev_busy;
        exp_next  = RST_PC;
        prev_addr = '0;
        prev_busy = 1'b0;
        forever begin
            mid();
            if (i_reset) begin
                check("rst_valid", 32'(o_valid), 32'd0);
                check("rst_rd", 32'(o_cache_rd), 32'd0);
                exp_next  = RST_PC;
                prev_busy = 1'b0;
            end else begin
                if (prev_busy) check("addr_hold_busy", o_cache_addr, prev_addr);
                if (o_valid && i_ready) begin
                    check("model_pc", o_pc, exp_next);
                    check("model_inst", o_inst, inst_of(exp_next));
                    exp_next = exp_next + 32'd4;
                end
                if (i_redirect) exp_next = {i_redirect_pc[31:2], 2'b00};
                check("addr_align", 32'(o_cache_addr[1:0]), 32'd0);
                prev_busy = i_cache_busy;
                prev_addr = o_cache_addr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int  n, m;
        bit  got, done, wrap_seen;
        logic [31:0] first_pc;

        // 1: sequential hits from reset
        i_ready = 1'b1;
        do_reset();
        mid();
        check("t1_first_valid", 32'(o_valid), 32'd0);
        check("t1_first_addr", o_cache_addr, 32'h0);
        check("t1_first_rd", 32'(o_cache_rd), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            check("t1_valid", 32'(o_valid), 32'd1);
            check("t1_pc", o_pc, 32'(i * 4));
        end

        // 2: decode stalls five cycles, FIFO fills, then drains without loss
        i_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            mid();
            if (c >= 2) begin
                check("t2_full_rd", 32'(o_cache_rd), 32'd0);
                check("t2_full_addr", o_cache_addr, 32'h8);
                check("t2_head_pc", o_pc, 32'h0);
            end
            tick();
        end
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("t2_release_pc", o_pc, 32'(i * 4));
            tick();
        end

        // 3: miss at 0x10 with an 8-cycle refill
        miss_addr = 32'h10;
        miss_len  = 8;
        do_reset();
        n = 0;
        m = 0;
        for (int i = 0; i < 30; i++) begin
            mid();
            if (o_valid && o_pc == 32'h10) n++;
            if (i_cache_busy) begin
                m++;
                check("t3_addr_during_refill", o_cache_addr, 32'h10);
            end
            tick();
        end
        check("t3_deliver_0x10_once", 32'(n), 32'd1);
        check("t3_refill_seen", 32'(m != 0), 32'd1);

        // 4: redirect to 0x200 during refill of 0x40
        miss_addr = 32'h40;
        miss_len  = 6;
        do_reset();
        wait_busy("t4_busy_bound");
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        tick();
        i_redirect = 1'b0;
        n = 0;
        got  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (o_valid && o_pc == 32'h40) n++;
            if (o_valid && o_pc == 32'h200) got = 1'b1;
            if (!done && !i_cache_busy && o_cache_rd) begin
                check("t4_next_fetch", o_cache_addr, 32'h200);
                done = 1'b1;
            end
            tick();
        end
        check("t4_0x40_never", 32'(n), 32'd0);
        check("t4_0x200_delivered", 32'(got), 32'd1);
        check("t4_fetch_resumed", 32'(done), 32'd1);

        // 5: two redirects in one refill, newest wins
        miss_addr = 32'h20;
        miss_len  = 10;
        do_reset();
        wait_busy("t5_busy_bound");
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        tick();
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h300;
        tick();
        i_redirect = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (o_valid && o_pc == 32'h100) n++;
            if (o_valid && o_pc == 32'h300) got = 1'b1;
            tick();
        end
        check("t5_0x100_never", 32'(n), 32'd0);
        check("t5_0x300_delivered", 32'(got), 32'd1);

        // 6: redirect with low bits set, then PC wrap past 0xFFFF_FFFC
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFA;
        tick();
        i_redirect = 1'b0;
        wrap_seen = 1'b0;
        done      = 1'b0;
        got       = 1'b0;
        first_pc  = '0;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (!got && o_valid) begin
                first_pc = o_pc;
                got      = 1'b1;
            end
            if (wrap_seen) begin
                check("t6_wrap_addr", o_cache_addr, 32'h0);
                wrap_seen = 1'b0;
                done      = 1'b1;
            end
            if (o_cache_rd && i_cache_hit && o_cache_addr == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            tick();
        end
        check("t6_first_pc_masked", first_pc, 32'hFFFF_FFF8);
        check("t6_wrap_checked", 32'(done), 32'd1);

        // 7: reset (with a coincident redirect) during a refill
        miss_addr = 32'h8;
        miss_len  = 10;
        do_reset();
        wait_busy("t7_busy_bound");
        tick();
        i_reset       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h500;
        mid();
        check("t7_rst_valid", 32'(o_valid), 32'd0);
        check("t7_rst_rd", 32'(o_cache_rd), 32'd0);
        tick();
        i_reset    = 1'b0;
        i_redirect = 1'b0;
        mid();
        check("t7_post_valid", 32'(o_valid), 32'd0);
        check("t7_post_addr", o_cache_addr, RST_PC);
        check("t7_post_rd", 32'(o_cache_rd), 32'd1);
        for (int i = 0; i < 12; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
